spi_master_arbiter: RTL and testbench



---
 rtl/spi_master_arbiter_if.sv | 32 +++
 rtl/spi_master_arbiter.sv | 169 ++++++++++++++++
 tb/tb_spi_master_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the shared spi_master.
// master: the arbiter side (drives grants, done, read data and the spi_master controls).
// slave : the client/spi_master side (drives requests, operands, chip select and read data).
interface spi_master_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [8*NUM_REQ-1:0]  req_cmd;
  logic [24*NUM_REQ-1:0] req_addr;
  logic [32*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    done;
  logic [31:0]           rdata;
  logic                  busy;
  logic                  err;
  logic                  spi_en;
  logic [7:0]            spi_command;
  logic [23:0]           spi_address;
  logic [31:0]           spi_data;
  logic                  spi_cs;
  logic [31:0]           spi_rdata;

  modport master (
    input  req, req_cmd, req_addr, req_wdata, spi_cs, spi_rdata,
    output gnt, done, rdata, busy, err, spi_en, spi_command, spi_address, spi_data
  );

  modport slave (
    output req, req_cmd, req_addr, req_wdata, spi_cs, spi_rdata,
    input  gnt, done, rdata, busy, err, spi_en, spi_command, spi_address, spi_data
  );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter/sequencer sharing one spi_master among NUM_REQ requesters.
// A grant latches the winner's operands, pulses spi_en once, follows the chip-select
// low phase to find the end of the transfer, then returns read data and a done pulse.
// Optional watchdog: define SPI_ARB_TIMEOUT_EN to bound each chip-select wait phase to
// TIMEOUT_CYCLES clocks; on expiry err sets (sticky) and rdata reads 32'hDEAD_BEEF.
module spi_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_master_arbiter_if.master bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_LOW, S_WAIT_HIGH, S_DONE
  } state_t;

  state_t             state_q;
  logic [IW-1:0]      ptr_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [NUM_REQ-1:0] done_q;
  logic [31:0]        rdata_q;
  logic               busy_q;
  logic               en_q;
  logic [7:0]         cmd_q;
  logic [23:0]        addr_q;
  logic [31:0]        data_q;

  // Per-requester operand views so the winner can be selected by index.
  logic [7:0]  cmd_arr  [NUM_REQ];
  logic [23:0] addr_arr [NUM_REQ];
  logic [31:0] data_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign cmd_arr[gi]  = bus.req_cmd[8*gi +: 8];
      assign addr_arr[gi] = bus.req_addr[24*gi +: 24];
      assign data_arr[gi] = bus.req_wdata[32*gi +: 32];
    end
  endgenerate

  logic [IW-1:0]      win_d;
  logic [IW-1:0]      ptr_d;
  logic [NUM_REQ-1:0] onehot_d;
  logic [IW-1:0]      scan_idx;
  logic               found;
  int                 j;

  // First set request bit scanning upward from the pointer, wrapping at NUM_REQ.
  always_comb begin
    win_d    = ptr_q;
    found    = 1'b0;
    j        = 0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      scan_idx = IW'(j);
      if (!found && bus.req[scan_idx]) begin
        found = 1'b1;
        win_d = scan_idx;
      end
    end
    ptr_d    = (int'(win_d) == NUM_REQ - 1) ? '0 : win_d + 1'b1;
    onehot_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_d;
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;
`endif

  // Sequencer: grant, launch, follow chip select, report completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      cmd_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (|bus.req) begin
            gnt_q   <= onehot_d;
            ptr_q   <= ptr_d;
            cmd_q   <= cmd_arr[win_d];
            addr_q  <= addr_arr[win_d];
            data_q  <= data_arr[win_d];
            busy_q  <= 1'b1;
            state_q <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          en_q    <= 1'b1;
          state_q <= S_WAIT_LOW;
`ifdef SPI_ARB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        S_WAIT_LOW: begin
          en_q <= 1'b0;
          if (!bus.spi_cs) begin
            state_q <= S_WAIT_HIGH;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_q   <= '0;
          end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            err_q   <= 1'b1;
            rdata_q <= 32'hDEAD_BEEF;
            done_q  <= gnt_q;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
`endif
          end
        end
        S_WAIT_HIGH: begin
          if (bus.spi_cs) begin
            rdata_q <= bus.spi_rdata;
            done_q  <= gnt_q;
            state_q <= S_DONE;
`ifdef SPI_ARB_TIMEOUT_EN
          end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            err_q   <= 1'b1;
            rdata_q <= 32'hDEAD_BEEF;
            done_q  <= gnt_q;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
`endif
          end
        end
        S_DONE: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.done        = done_q;
  assign bus.rdata       = rdata_q;
  assign bus.busy        = busy_q;
  assign bus.spi_en      = en_q;
  assign bus.spi_command = cmd_q;
  assign bus.spi_address = addr_q;
  assign bus.spi_data    = data_q;
`ifdef SPI_ARB_TIMEOUT_EN
  assign bus.err         = err_q;
`else
  assign bus.err         = 1'b0;
`endif
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: a transaction-level reference model predicts every
// output each cycle, an spi_master stand-in answers spi_en with a chip-select pulse,
// and directed scenarios pin the model with literal expectations.
module tb_spi_master_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_arbiter_if #(.NUM_REQ(N)) bus();

  spi_master_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  logic          m_active, m_launched, m_low, m_fin, m_busy, m_en, m_err;
  int            m_ptr, m_wcnt;
  logic [N-1:0]  m_gnt, m_done;
  logic [31:0]   m_rdata, m_data;
  logic [7:0]    m_cmd;
  logic [23:0]   m_addr;

  // A grant starts a transaction; the edge after it launches; from then on the model
  // waits for cs low then cs high (or the watchdog), and spends one cycle reporting.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 0; m_launched <= 0; m_low <= 0; m_fin <= 0; m_busy <= 0; m_en <= 0;
      m_err <= 0; m_ptr <= 0; m_wcnt <= 0; m_gnt <= '0; m_done <= '0; m_rdata <= '0;
      m_data <= '0; m_cmd <= '0; m_addr <= '0;
    end else begin
      m_done <= '0;
      if (!m_active) begin
        if (bus.req != '0) begin
          m_active   <= 1; m_launched <= 0; m_low <= 0; m_wcnt <= 0; m_fin <= 0; m_busy <= 1;
          m_gnt  <= N'(1 << pick(bus.req, m_ptr));
          m_cmd  <= bus.req_cmd[8*pick(bus.req, m_ptr) +: 8];
          m_addr <= bus.req_addr[24*pick(bus.req, m_ptr) +: 24];
          m_data <= bus.req_wdata[32*pick(bus.req, m_ptr) +: 32];
          m_ptr  <= (pick(bus.req, m_ptr) + 1) % N;
        end
      end else if (m_fin) begin
        m_active <= 0; m_gnt <= '0; m_busy <= 0; m_fin <= 0;
      end else if (!m_launched) begin
        m_launched <= 1; m_en <= 1;
      end else begin
        m_en <= 0;
        if (!m_low && !bus.spi_cs) begin
          m_low <= 1; m_wcnt <= 0;
        end else if (m_low && bus.spi_cs) begin
          m_rdata <= bus.spi_rdata; m_done <= m_gnt; m_fin <= 1;
        end else if (TO_ON && m_wcnt == TO - 1) begin
          m_err <= 1; m_rdata <= 32'hDEAD_BEEF; m_done <= m_gnt; m_fin <= 1;
        end else begin
          m_wcnt <= m_wcnt + 1;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  int glog[$];
  int waitc [N];
  int done_cnt [N];
  int done_total = 0;

  initial begin
    logic [N-1:0] pg;
    int w;
    pg = '0;
    for (int i = 0; i < N; i++) begin waitc[i] = 0; done_cnt[i] = 0; end
    forever begin
      @(negedge clk);
      chk("gnt",    32'(bus.gnt),  32'(m_gnt));
      chk("done",   32'(bus.done), 32'(m_done));
      chk("rdata",  bus.rdata,     m_rdata);
      chk("busy",   32'(bus.busy), 32'(m_busy));
      chk("err",    32'(bus.err),  32'(m_err));
      chk("spi_en", 32'(bus.spi_en), 32'(m_en));
      chk("spi_command", 32'(bus.spi_command), 32'(m_cmd));
      chk("spi_address", 32'(bus.spi_address), 32'(m_addr));
      chk("spi_data",    bus.spi_data,         m_data);
      chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      if (bus.gnt != '0 && pg == '0) begin
        w = 0;
        for (int i = 0; i < N; i++) if (bus.gnt[i]) w = i;
        glog.push_back(w);
        for (int i = 0; i < N; i++) begin
          if (i == w) waitc[i] = 0;
          else if (bus.req[i]) begin
            waitc[i]++;
            chk($sformatf("fairness_req%0d", i), 32'(waitc[i] <= N - 1), 32'd1);
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i]) waitc[i] = 0;
        if (bus.done[i]) begin done_cnt[i]++; done_total++; end
      end
      pg = bus.gnt;
    end
  end

  // ---------------- spi_master stand-in ----------------
  bit          emu_on = 1, emu_rand = 0, emu_early = 0;
  int          emu_delay = 0, emu_len = 4;
  logic [31:0] emu_rdata = 32'h0;

  initial begin
    logic pg, gr;
    int d, l;
    bus.spi_cs = 1'b1; bus.spi_rdata = '0; pg = 1'b0;
    forever begin
      @(negedge clk);
      gr = (bus.gnt != '0) && !pg;
      pg = (bus.gnt != '0);
      if (emu_on && rst_n && (emu_early ? gr : bus.spi_en)) begin
        d = emu_early ? 0 : (emu_rand ? int'($urandom_range(3, 0)) : emu_delay);
        l = emu_rand ? int'($urandom_range(8, 1)) : emu_len;
        if (emu_early && l < 2) l = 2;
        #1;
        for (int c = 0; c < d; c++) begin @(negedge clk); #1; end
        bus.spi_cs = 1'b0;
        bus.spi_rdata = emu_rand ? $urandom : emu_rdata;
        repeat (l) @(negedge clk);
        #1 bus.spi_cs = 1'b1;
        if (emu_rand) emu_early = ($urandom_range(3, 0) == 0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_ops(input int i, input logic [7:0] c, input logic [23:0] a, input logic [31:0] d);
    bus.req_cmd[8*i +: 8]    = c;
    bus.req_addr[24*i +: 24] = a;
    bus.req_wdata[32*i +: 32] = d;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0; bus.req = '0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_done_any(input int budget, output int idx);
    idx = -1;
    for (int c = 0; c < budget && idx < 0; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (bus.done[i]) idx = i;
    end
    chk("done_within_budget", 32'(idx >= 0), 32'd1);
  endtask

  task automatic step_reqs(input bit allow_raise);
    logic [N-1:0] d, g;
    @(negedge clk);
    d = bus.done; g = bus.gnt;
    #1;
    for (int i = 0; i < N; i++) begin
      if (d[i]) begin
        if (!allow_raise || $urandom_range(1, 0) == 0) bus.req[i] = 1'b0;
        else set_ops(i, 8'($urandom), 24'($urandom), $urandom);
      end else if (!bus.req[i] && !g[i] && allow_raise && $urandom_range(4, 0) == 0) begin
        set_ops(i, 8'($urandom), 24'($urandom), $urandom);
        bus.req[i] = 1'b1;
      end else if (bus.req[i] && g[i] && allow_raise && $urandom_range(9, 0) == 0) begin
        bus.req[i] = 1'b0;
      end
    end
  endtask

  // ---------------- directed and random scenarios ----------------
  initial begin
    int idx, base, n;
    bit seen;
    bus.req = '0; bus.req_cmd = '0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_gnt", 32'(bus.gnt), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_rdata", bus.rdata, 32'd0);
    chk("reset_spi_en", 32'(bus.spi_en), 32'd0);
    #1 rst_n = 1'b1;

    // Single request with a 40-cycle chip-select low phase.
    emu_delay = 1; emu_len = 40; emu_rdata = 32'hCAFEF00D;
    @(negedge clk); #1;
    set_ops(0, 8'hA5, 24'h123456, 32'h789ABCDE);
    bus.req = 4'b0001;
    @(negedge clk);
    chk("single_gnt_latency", 32'(bus.gnt), 32'h1);
    chk("single_en_not_yet", 32'(bus.spi_en), 32'd0);
    @(negedge clk);
    chk("single_spi_en", 32'(bus.spi_en), 32'd1);
    chk("single_cmd", 32'(bus.spi_command), 32'hA5);
    chk("single_addr", 32'(bus.spi_address), 32'h123456);
    chk("single_data", bus.spi_data, 32'h789ABCDE);
    @(negedge clk);
    chk("single_en_one_cycle", 32'(bus.spi_en), 32'd0);
    wait_done_any(80, idx);
    chk("single_done_idx", 32'(idx), 32'd0);
    chk("single_rdata", bus.rdata, 32'hCAFEF00D);
    #1 bus.req = '0;
    repeat (5) @(negedge clk);
    chk("single_done_count", 32'(done_cnt[0]), 32'd1);
    chk("single_ops_held", bus.spi_data, 32'h789ABCDE);

    // Round robin with all four requesting.
    emu_rand = 1;
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, 8'($urandom), 24'($urandom), $urandom);
    glog.delete(); base = done_total;
    bus.req = 4'b1111;
    for (int t = 0; t < 5; t++) wait_done_any(60, idx);
    #1 bus.req = '0;
    repeat (4) @(negedge clk);
    chk("rr_count", 32'(glog.size()), 32'd5);
    chk("rr_done_count", 32'(done_total - base), 32'd5);
    if (glog.size() >= 5) begin
      chk("rr_order0", 32'(glog[0]), 32'd0);
      chk("rr_order1", 32'(glog[1]), 32'd1);
      chk("rr_order2", 32'(glog[2]), 32'd2);
      chk("rr_order3", 32'(glog[3]), 32'd3);
      chk("rr_order4", 32'(glog[4]), 32'd0);
    end

    // Wrap: serve requester 2 so the pointer sits at 3, then ask with 0 and 2.
    do_reset();
    set_ops(2, 8'h22, 24'h000222, 32'h2222);
    bus.req = 4'b0100;
    wait_done_any(60, idx);
    #1 bus.req = '0;
    repeat (2) @(negedge clk);
    glog.delete();
    #1;
    set_ops(0, 8'h10, 24'h000010, 32'h1010);
    bus.req = 4'b0101;
    wait_done_any(60, idx);
    #1 bus.req[idx] = 1'b0;
    wait_done_any(60, idx);
    #1 bus.req = '0;
    repeat (2) @(negedge clk);
    chk("wrap_count", 32'(glog.size()), 32'd2);
    if (glog.size() >= 2) begin
      chk("wrap_first", 32'(glog[0]), 32'd0);
      chk("wrap_second", 32'(glog[1]), 32'd2);
    end

    // Request dropped while waiting for chip select to rise.
    emu_rand = 0; emu_delay = 0; emu_len = 10; emu_rdata = 32'h0BADC0DE;
    @(negedge clk); #1;
    set_ops(1, 8'h3C, 24'hABCDEF, 32'h01234567);
    bus.req = 4'b0010;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin @(negedge clk); seen = !bus.spi_cs; end
    chk("drop_cs_low_seen", 32'(seen), 32'd1);
    @(negedge clk); #1 bus.req = '0;
    base = done_cnt[1];
    wait_done_any(40, idx);
    chk("drop_done_idx", 32'(idx), 32'd1);
    chk("drop_rdata", bus.rdata, 32'h0BADC0DE);
    @(negedge clk);
    chk("drop_busy_falls", 32'(bus.busy), 32'd0);
    chk("drop_done_once", 32'(done_cnt[1] - base), 32'd1);

    // Reset while waiting for chip select to fall.
    emu_delay = 4; emu_len = 4;
    @(negedge clk); #1;
    bus.req = 4'b0001;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin @(negedge clk); seen = bus.spi_en; end
    chk("rst_mid_en_seen", 32'(seen), 32'd1);
    #2 rst_n = 1'b0; bus.req = '0;
    #1;
    chk("rst_mid_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_mid_spi_en", 32'(bus.spi_en), 32'd0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    base = done_total;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("rst_mid_no_done", 32'(done_total - base), 32'd0);

    // Randomized traffic, then drain.
    emu_rand = 1;
    repeat (2500) step_reqs(1'b1);
    seen = 0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      step_reqs(1'b0);
      seen = (bus.req == '0) && !bus.busy;
    end
    chk("random_drained", 32'(seen), 32'd1);
    emu_rand = 0; emu_early = 0;
    repeat (15) @(negedge clk);

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog with chip select stuck high.
    do_reset();
    emu_on = 0;
    bus.req = 4'b0001;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin @(negedge clk); seen = bus.spi_en; end
    n = 0; idx = -1;
    for (int c = 0; c < 100 && idx < 0; c++) begin
      @(negedge clk); n++;
      if (bus.done[0]) idx = 0;
    end
    chk("timeout_latency", 32'(n), 32'd16);
    chk("timeout_err", 32'(bus.err), 32'd1);
    chk("timeout_rdata", bus.rdata, 32'hDEAD_BEEF);
    #1 bus.req = '0;
    repeat (5) @(negedge clk);
    chk("timeout_err_sticky", 32'(bus.err), 32'd1);
    do_reset();
    @(negedge clk);
    chk("timeout_err_cleared", 32'(bus.err), 32'd0);
    emu_on = 1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
